// File: rtl/extractor16_seq.sv
// Lane sequencer: accepts a 16-bit word and lane mask, then emits the enabled lanes one per cycle.
// Define EXTRACT_MSB_FIRST_EN to emit the highest index first. The default order is lowest index first.
module extractor16_seq #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] rem_r;
  logic             done_r;
  logic [IDX_W-1:0] idx;
  logic             last;

  // Select the next lane from the remaining mask.
  // The last match found in the loop wins, so the loop direction sets the priority.
  always_comb begin
    idx = '0;
`ifdef EXTRACT_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (rem_r[i]) idx = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rem_r[i]) idx = IDX_W'(i);
`endif
  end

  assign last      = (rem_r != '0) && ((rem_r & (rem_r - 1'b1)) == '0);
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign in_ready  = (state == IDLE);
  assign out_idx   = out_valid ? idx : '0;
  assign out_bit   = out_valid & data_r[idx];
  assign out_last  = out_valid & last;
  assign done      = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
      rem_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // abort takes priority over a word offered in the same cycle. That word is dropped.
          if (!abort && in_valid) begin
            data_r <= in_data;
            rem_r  <= in_mask;
            if (in_mask != '0) state  <= SEND;
            else               done_r <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
            rem_r <= '0;
          end else if (out_ready) begin
            rem_r[idx] <= 1'b0;
            if (last) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extractor16_seq.sv
// Scoreboard testbench for extractor16_seq. A model pushes the expected beats when a word is offered.
module tb_extractor16_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, abort, out_valid, out_ready, out_bit, out_last, done, busy;
  logic [15:0] in_data, in_mask;
  logic [3:0]  out_idx;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb_q[$];  // {idx, bit, last}

  extractor16_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_idx(out_idx), .out_last(out_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push_expected(input logic [15:0] d, input logic [15:0] m);
    int left;
    int j;
    left = $countones(m);
    for (int k = 0; k < 16; k++) begin
`ifdef EXTRACT_MSB_FIRST_EN
      j = 15 - k;
`else
      j = k;
`endif
      if (m[j]) begin
        sb_q.push_back({4'(j), d[j], left == 1});
        left--;
      end
    end
  endtask

  // Offers one word. Then it drives out_ready from the pattern (bit cyc%16) and checks every beat.
  // If abort_at >= 0, abort is raised after that many beats have been consumed.
  task automatic run_word(input string nm, input logic [15:0] d, input logic [15:0] m,
                          input logic [15:0] pat, input int abort_at);
    int   beats = 0;
    bit   fin = 0, ab = 0, stalled = 0;
    logic [5:0] exp_b, held;
    push_expected(d, m);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", nm, in_ready); end
    in_valid = 1'b1; in_data = d; in_mask = m;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'($urandom); in_mask = 16'($urandom);
    if (m == 16'h0) begin
      checks++; if ({done, out_valid, in_ready} !== 3'b101) begin errors++;
        $display("FAIL %s empty done/valid/ready got %b want 101", nm, {done, out_valid, in_ready}); end
      @(negedge clk);
      checks++; if ({done, out_valid} !== 2'b00) begin errors++; $display("FAIL %s empty after got %b want 00", nm, {done, out_valid}); end
      return;
    end
    for (int cyc = 0; cyc < 200 && !fin && !ab; cyc++) begin
      out_ready = pat[cyc % 16];
      checks++; if ({out_valid, busy, in_ready, done} !== 4'b1100) begin errors++;
        $display("FAIL %s send status got %b want 1100", nm, {out_valid, busy, in_ready, done}); end
      if (stalled) begin
        checks++; if ({out_idx, out_bit, out_last} !== held) begin errors++;
          $display("FAIL %s stall hold got %h want %h", nm, {out_idx, out_bit, out_last}, held); end
      end
      if (abort_at == beats) begin
        abort = 1'b1; out_ready = 1'b0; ab = 1;
      end else if (out_ready) begin
        if (sb_q.size() == 0) begin errors++; checks++; $display("FAIL %s extra beat idx %0d want none", nm, out_idx); end
        else begin
          exp_b = sb_q.pop_front();
          checks++; if ({out_idx, out_bit, out_last} !== exp_b) begin errors++;
            $display("FAIL %s beat %0d idx/bit/last got %0d/%b/%b want %0d/%b/%b", nm, beats,
                     out_idx, out_bit, out_last, exp_b[5:2], exp_b[1], exp_b[0]); end
          if (exp_b[0]) fin = 1;
        end
        beats++;
      end
      stalled = !out_ready;
      held = {out_idx, out_bit, out_last};
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (ab) begin
      abort = 1'b0;
      sb_q.delete();
      checks++; if ({out_valid, done, in_ready} !== 3'b001) begin errors++;
        $display("FAIL %s abort valid/done/ready got %b want 001", nm, {out_valid, done, in_ready}); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s abort late done got %b want 0", nm, done); end
      return;
    end
    if (!fin) begin errors++; checks++; $display("FAIL %s timeout beats %0d want last", nm, beats); end
    checks++; if ({done, out_valid, busy, in_ready} !== 4'b1001) begin errors++;
      $display("FAIL %s done/valid/busy/ready got %b want 1001", nm, {done, out_valid, busy, in_ready}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done width got %b want 0", nm, done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_mask = 0; abort = 0; out_ready = 0;
    #12;
    checks++; if ({out_valid, out_bit, out_idx, out_last, done, busy} !== 9'b0) begin errors++;
      $display("FAIL reset_outputs got %b want 0", {out_valid, out_bit, out_idx, out_last, done, busy}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1; in_data = 16'hFFFF; in_mask = 16'h00F0;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_send got %b want 1", out_valid); end
    rst_n = 1'b0; #1;
    checks++; if ({out_valid, out_bit, out_idx, out_last, done, busy} !== 9'b0) begin errors++;
      $display("FAIL midreset_outputs got %b want 0", {out_valid, out_bit, out_idx, out_last, done, busy}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({in_ready, done, out_valid} !== 3'b100) begin errors++;
      $display("FAIL midreset_after got %b want 100", {in_ready, done, out_valid}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
  endtask

  task automatic test_full_mask();
    run_word("full", 16'hA5C3, 16'hFFFF, 16'hFFFF, -1);
  endtask

  task automatic test_sparse_backpressure();
    run_word("sparse", 16'h8001, 16'h8101, 16'b1111_1111_1111_1001, -1);
  endtask

  task automatic test_empty_mask();
    run_word("empty", 16'h1234, 16'h0000, 16'hFFFF, -1);
  endtask

  task automatic test_abort();
    run_word("abort", 16'hFFFF, 16'h000F, 16'hFFFF, 2);
    run_word("post_abort", 16'h0002, 16'h0002, 16'hFFFF, -1);
    // An abort in IDLE beats a word offered in the same cycle.
    @(negedge clk); in_valid = 1; abort = 1; in_mask = 16'h0001; in_data = 16'h0001;
    @(negedge clk); in_valid = 0; abort = 0;
    checks++; if ({out_valid, in_ready, done} !== 3'b010) begin errors++;
      $display("FAIL idle_abort got %b want 010", {out_valid, in_ready, done}); end
  endtask

  task automatic test_back_to_back();
    run_word("b2b_a", 16'h5A3C, 16'h0F0F, 16'b1011_0110_1101_0111, -1);
    run_word("b2b_b", 16'hC33C, 16'hF00F, 16'hFFFF, -1);
    for (int n = 0; n < 4; n++)
      run_word("rand", 16'($urandom), 16'($urandom), 16'($urandom) | 16'h0001, -1);
  endtask

  initial begin
    test_reset();
    test_reset_mid_word();
    test_full_mask();
    test_sparse_backpressure();
    test_empty_mask();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
